// File: rtl/projectile_scheduler_if.sv
// projectile_scheduler_if: player inputs, tick strobe and slot/grant/hit outputs of the projectile scheduler.
interface projectile_scheduler_if;
    logic       tick;
    logic       p1_req, p2_req;
    logic [6:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_mirrored, p2_mirrored;
    logic       slot0_en, slot1_en;
    logic [6:0] slot0_x, slot0_y, slot1_x, slot1_y;
    logic       slot0_owner, slot1_owner;
    logic       grant_p1, grant_p2;
    logic       hit_p1, hit_p2;
    modport slave (
        input  tick, p1_req, p2_req, p1_x, p1_y, p2_x, p2_y, p1_mirrored, p2_mirrored,
        output slot0_en, slot1_en, slot0_x, slot0_y, slot1_x, slot1_y,
               slot0_owner, slot1_owner, grant_p1, grant_p2, hit_p1, hit_p2
    );
    modport master (
        output tick, p1_req, p2_req, p1_x, p1_y, p2_x, p2_y, p1_mirrored, p2_mirrored,
        input  slot0_en, slot1_en, slot0_x, slot0_y, slot1_x, slot1_y,
               slot0_owner, slot1_owner, grant_p1, grant_p2, hit_p1, hit_p2
    );
endinterface

// File: rtl/projectile_scheduler.sv
// projectile_scheduler: two shared projectile slots, arbitrated between both players, stepped on tick and retired on hit or screen edge.
module projectile_scheduler #(
    parameter int SCREEN_W       = 96,
    parameter int BULLET_RADIUS  = 4,
    parameter int RAISE_BULLET   = 5,
    parameter int COOLDOWN_TICKS = 20
) (
    input logic clk,
    input logic rst,
    projectile_scheduler_if.slave b
);
    localparam int CW = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [7:0] R = 8'(BULLET_RADIUS);
    localparam logic [7:0] RB = 8'(RAISE_BULLET);
    localparam logic [6:0] RB7 = 7'(RAISE_BULLET);
    localparam logic [7:0] XMAX = 8'(SCREEN_W - BULLET_RADIUS);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_TICKS);

    typedef enum logic [1:0] {IDLE, SPAWN, FLY} state_t;

    state_t        state_q [2], state_d [2];
    logic [6:0]    x_q [2], x_d [2], y_q [2], y_d [2];
    logic          own_q [2], own_d [2], dir_q [2], dir_d [2];
    logic [CW-1:0] cd_q [2], cd_d [2];
    logic [1:0]    prev_q, prev_d, pend_q, pend_d;
    logic [1:0]    grant_q, grant_d, hit_q, hit_d;
    logic          rr_q, rr_d;

    logic [1:0] req, mir, free, lf;
    logic [1:0] take [2];
    logic [6:0] px [2], py [2];
    logic       w, opp, hit, edge_r;
    logic [7:0] ox, oy, sx, sy;

    assign req = {b.p2_req, b.p1_req};
    assign mir = {b.p2_mirrored, b.p1_mirrored};
    assign px[0] = b.p1_x;
    assign px[1] = b.p2_x;
    assign py[0] = b.p1_y;
    assign py[1] = b.p2_y;

    always_comb begin
        free = {state_q[1] == IDLE, state_q[0] == IDLE};
        lf = free[0] ? 2'b01 : {free[1], 1'b0};
        rr_d = rr_q;
        take[0] = 2'b00;
        take[1] = 2'b00;
        if (&pend_q && &free) begin
            take[0] = 2'b01;
            take[1] = 2'b10;
        end else if (&pend_q) begin
            // a single free slot goes to the favoured player; the pointer flips only when it was contested
            take[0] = rr_q ? 2'b00 : lf;
            take[1] = rr_q ? lf : 2'b00;
            rr_d = rr_q ^ (|free);
        end else begin
            take[0] = pend_q[0] ? lf : 2'b00;
            take[1] = pend_q[1] ? lf : 2'b00;
        end
        prev_d = req;
        grant_d = '0;
        pend_d = pend_q;
        for (int p = 0; p < 2; p++) begin
            grant_d[p] = |take[p];
            pend_d[p] = grant_d[p] ? 1'b0 : pend_q[p] | (req[p] & ~prev_q[p] & (cd_q[p] == '0));
            cd_d[p] = grant_d[p] ? CD_LOAD : (b.tick && cd_q[p] != '0) ? cd_q[p] - CW'(1) : cd_q[p];
        end
        hit_d = '0;
        w = 1'b0;
        opp = 1'b0;
        ox = '0;
        oy = '0;
        sx = '0;
        sy = '0;
        hit = 1'b0;
        edge_r = 1'b0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            own_d[i] = own_q[i];
            dir_d[i] = dir_q[i];
            w = take[1][i];
            opp = ~own_q[i];
            ox = {1'b0, px[opp]};
            oy = {1'b0, py[opp]};
            sx = {1'b0, x_q[i]};
            sy = {1'b0, y_q[i]};
            // box test moved to the positive side of each inequality so nothing can underflow
            hit = state_q[i] == FLY && sx + R >= ox && sx <= ox + R && sy + RB + R >= oy && sy + RB <= oy + R;
            edge_r = sx <= R || sx >= XMAX;
            if (state_q[i] == IDLE && (take[0][i] | take[1][i])) begin
                state_d[i] = SPAWN;
                own_d[i] = w;
                dir_d[i] = mir[w];
                x_d[i] = px[w];
                y_d[i] = py[w] >= RB7 ? py[w] - RB7 : 7'd0;
            end else if (state_q[i] == SPAWN) begin
                state_d[i] = FLY;
            end else if (hit) begin
                state_d[i] = IDLE;
                hit_d[opp] = 1'b1;
            end else if (state_q[i] == FLY && edge_r) begin
                state_d[i] = IDLE;
            end else if (state_q[i] == FLY && b.tick) begin
                x_d[i] = dir_q[i] ? x_q[i] - 7'd1 : x_q[i] + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '{default: IDLE};
            x_q <= '{default: '0};
            y_q <= '{default: '0};
            own_q <= '{default: 1'b0};
            dir_q <= '{default: 1'b0};
            cd_q <= '{default: '0};
            prev_q <= '0;
            pend_q <= '0;
            grant_q <= '0;
            hit_q <= '0;
            rr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            own_q <= own_d;
            dir_q <= dir_d;
            cd_q <= cd_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
            grant_q <= grant_d;
            hit_q <= hit_d;
            rr_q <= rr_d;
        end
    end

    assign b.slot0_en = state_q[0] == FLY;
    assign b.slot1_en = state_q[1] == FLY;
    assign b.slot0_x = x_q[0];
    assign b.slot0_y = y_q[0];
    assign b.slot1_x = x_q[1];
    assign b.slot1_y = y_q[1];
    assign b.slot0_owner = own_q[0];
    assign b.slot1_owner = own_q[1];
    assign b.grant_p1 = grant_q[0];
    assign b.grant_p2 = grant_q[1];
    assign b.hit_p1 = hit_q[0];
    assign b.hit_p2 = hit_q[1];
endmodule
